// File: rtl/morph_pass_scheduler_platedetection.sv
// Runs repeated dilate-engine passes over a frame held in two ping-pong banks:
// reset the engine, stream the source bank through it, write results to the other bank, swap.
module morph_pass_scheduler_platedetection #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned NUM_WORDS_FRAME = 4800,
  parameter int unsigned ADDR_WIDTH      = 13,
  parameter int unsigned PASS_WIDTH      = 4,
  parameter int unsigned ENG_RST_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [PASS_WIDTH-1:0] i_num_passes,
  input  logic                  i_src_bank,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_result_bank,
  output logic                  o_rd_en,
  output logic                  o_rd_bank,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_wr_en,
  output logic                  o_wr_bank,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_eng_reset,
  output logic                  o_eng_data_valid,
  output logic [DATA_WIDTH-1:0] o_eng_data,
  input  logic                  i_eng_data_valid,
  input  logic [DATA_WIDTH-1:0] i_eng_data,
  input  logic                  i_eng_end
);

  localparam int unsigned CntW  = ADDR_WIDTH + 1;
  localparam int unsigned RstW  = (ENG_RST_CYCLES > 1) ? $clog2(ENG_RST_CYCLES) : 1;
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CntW-1:0]       FrameWords = CntW'(NUM_WORDS_FRAME);
  localparam logic [RstW-1:0]       RstLast    = RstW'(ENG_RST_CYCLES - 1);
  localparam logic [IdleW-1:0]      IdleLast   = IdleW'(TIMEOUT_CYCLES - 1);
  localparam logic [IdleW-1:0]      IdleMax    = IdleW'(TIMEOUT_CYCLES);
  localparam logic [PASS_WIDTH-1:0] OnePass    = PASS_WIDTH'(1);

  typedef enum logic [2:0] {
    StIdle,
    StEngRst,
    StFeed,
    StDrain,
    StSwap,
    StDone
  } state_e;

  state_e                state_q;
  logic [PASS_WIDTH-1:0] pass_left_q;
  logic [RstW-1:0]       rst_cnt_q;
  logic [CntW-1:0]       rd_cnt_q;
  logic [CntW-1:0]       wr_cnt_q;
  logic [IdleW-1:0]      idle_cnt_q;

  // Read data already lines up with the delayed valid, so it feeds the engine directly.
  assign o_eng_data = i_rd_data;

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state_q          <= StIdle;
      pass_left_q      <= '0;
      rst_cnt_q        <= '0;
      rd_cnt_q         <= '0;
      wr_cnt_q         <= '0;
      idle_cnt_q       <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_error          <= 1'b0;
      o_result_bank    <= 1'b0;
      o_rd_en          <= 1'b0;
      o_rd_bank        <= 1'b0;
      o_rd_addr        <= '0;
      o_wr_en          <= 1'b0;
      o_wr_bank        <= 1'b1;
      o_wr_addr        <= '0;
      o_wr_data        <= '0;
      o_eng_reset      <= 1'b1;
      o_eng_data_valid <= 1'b0;
    end else begin
      o_done           <= 1'b0;
      o_wr_en          <= 1'b0;
      o_eng_data_valid <= o_rd_en;

      // Capture engine output; a word beyond the frame is dropped and flagged.
      if (state_q == StFeed || state_q == StDrain) begin
        if (i_eng_data_valid) begin
          idle_cnt_q <= '0;
          if (wr_cnt_q == FrameWords) begin
            o_error <= 1'b1;
          end else begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= wr_cnt_q[ADDR_WIDTH-1:0];
            o_wr_data <= i_eng_data;
            wr_cnt_q  <= wr_cnt_q + CntW'(1);
          end
        end else if (idle_cnt_q != IdleMax) begin
          idle_cnt_q <= idle_cnt_q + IdleW'(1);
        end
      end

      unique case (state_q)
        StIdle: begin
          o_eng_reset <= 1'b1;
          if (i_start) begin
            o_error     <= 1'b0;
            pass_left_q <= i_num_passes;
            o_rd_bank   <= i_src_bank;
            o_wr_bank   <= ~i_src_bank;
            if (i_num_passes == '0) begin
              o_done        <= 1'b1;
              o_result_bank <= i_src_bank;
            end else begin
              state_q   <= StEngRst;
              o_busy    <= 1'b1;
              rst_cnt_q <= '0;
            end
          end
        end

        StEngRst: begin
          wr_cnt_q   <= '0;
          idle_cnt_q <= '0;
          if (rst_cnt_q == RstLast) begin
            o_eng_reset <= 1'b0;
            o_rd_en     <= 1'b1;
            o_rd_addr   <= '0;
            rd_cnt_q    <= CntW'(1);
            state_q     <= StFeed;
          end else begin
            rd_cnt_q  <= '0;
            rst_cnt_q <= rst_cnt_q + RstW'(1);
          end
        end

        StFeed: begin
          if (rd_cnt_q == FrameWords) begin
            o_rd_en <= 1'b0;
            state_q <= StDrain;
          end else begin
            o_rd_addr <= rd_cnt_q[ADDR_WIDTH-1:0];
            rd_cnt_q  <= rd_cnt_q + CntW'(1);
          end
        end

        StDrain: begin
          if (wr_cnt_q == FrameWords && i_eng_end) begin
            state_q <= StSwap;
          end else if (!i_eng_data_valid && idle_cnt_q >= IdleLast) begin
            // Engine stalled: give up on the frame but still report completion.
            o_error       <= 1'b1;
            o_done        <= 1'b1;
            o_result_bank <= ~o_rd_bank;
            o_eng_reset   <= 1'b1;
            o_busy        <= 1'b0;
            state_q       <= StIdle;
          end
        end

        StSwap: begin
          o_rd_bank   <= ~o_rd_bank;
          o_wr_bank   <= o_rd_bank;
          pass_left_q <= pass_left_q - OnePass;
          o_eng_reset <= 1'b1;
          if (pass_left_q > OnePass) begin
            rst_cnt_q <= '0;
            state_q   <= StEngRst;
          end else begin
            o_done        <= 1'b1;
            o_result_bank <= ~o_rd_bank;
            state_q       <= StDone;
          end
        end

        StDone: begin
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_morph_pass_scheduler_platedetection.sv
// Bench for the pass scheduler: bank memories and a latency-3 echo engine are modelled here,
// reads and writes are checked against queued expectations.
module tb_morph_pass_scheduler_platedetection;

  localparam int DW = 64;
  localparam int NW = 16;
  localparam int AW = 5;
  localparam int PW = 4;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_start = 1'b0;
  logic [PW-1:0] i_num_passes = '0;
  logic          i_src_bank = 1'b0;
  logic          o_busy, o_done, o_error, o_result_bank;
  logic          o_rd_en, o_rd_bank, o_wr_en, o_wr_bank;
  logic [AW-1:0] o_rd_addr, o_wr_addr;
  logic [DW-1:0] i_rd_data, o_wr_data, o_eng_data, i_eng_data;
  logic          o_eng_reset, o_eng_data_valid, i_eng_data_valid, i_eng_end;

  always #5 clk = ~clk;

  morph_pass_scheduler_platedetection #(
    .DATA_WIDTH      (DW),
    .NUM_WORDS_FRAME (NW),
    .ADDR_WIDTH      (AW),
    .PASS_WIDTH      (PW),
    .ENG_RST_CYCLES  (2),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk              (clk),
    .i_reset_n        (i_reset_n),
    .i_start          (i_start),
    .i_num_passes     (i_num_passes),
    .i_src_bank       (i_src_bank),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_error          (o_error),
    .o_result_bank    (o_result_bank),
    .o_rd_en          (o_rd_en),
    .o_rd_bank        (o_rd_bank),
    .o_rd_addr        (o_rd_addr),
    .i_rd_data        (i_rd_data),
    .o_wr_en          (o_wr_en),
    .o_wr_bank        (o_wr_bank),
    .o_wr_addr        (o_wr_addr),
    .o_wr_data        (o_wr_data),
    .o_eng_reset      (o_eng_reset),
    .o_eng_data_valid (o_eng_data_valid),
    .o_eng_data       (o_eng_data),
    .i_eng_data_valid (i_eng_data_valid),
    .i_eng_data       (i_eng_data),
    .i_eng_end        (i_eng_end)
  );

  // Two banks, 1-cycle read latency.
  logic [DW-1:0] mem [2][NW];
  always @(posedge clk) begin
    if (o_rd_en) i_rd_data <= mem[o_rd_bank][int'(o_rd_addr)];
    if (o_wr_en) mem[o_wr_bank][int'(o_wr_addr)] = o_wr_data;
  end

  // Engine: echo with latency 3. mode 1 adds a 17th word, mode 2 stops after 10 words.
  int            mode = 0;
  logic [2:0]    pv = '0;
  logic [DW-1:0] pd0, pd1, pd2;
  int            emitted = 0;
  logic          eng_end = 1'b0;
  logic          eng_v;

  always_comb begin
    eng_v = pv[2];
    if (mode == 1 && emitted == NW) eng_v = 1'b1;
    if (mode == 2 && emitted >= 10) eng_v = 1'b0;
  end
  assign i_eng_data_valid = eng_v;
  assign i_eng_data       = pd2;
  assign i_eng_end        = eng_end;

  always @(posedge clk) begin
    if (o_eng_reset) begin
      pv      <= '0;
      emitted <= 0;
      eng_end <= 1'b0;
    end else begin
      pv      <= {pv[1:0], o_eng_data_valid};
      pd0     <= o_eng_data;
      pd1     <= pd0;
      pd2     <= pd1;
      emitted <= emitted + (eng_v ? 1 : 0);
      eng_end <= (emitted + (eng_v ? 1 : 0)) >= ((mode == 1) ? NW + 1 : NW);
    end
  end

  typedef struct {
    logic          bank;
    int            addr;
    logic [DW-1:0] data;
  } acc_t;

  typedef struct {
    string         name;
    int            np;
    logic          src;
    int            mode;
    int            words;
    logic          exp_bank;
    logic          exp_err;
    logic          exp_busy;
  } vec_t;

  acc_t rdq[$];
  acc_t wrq[$];
  acc_t re, we;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   last_wr_cyc = 0;
  int   falls = 0;
  int   run = 0;
  logic rst_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] pat(int a);
    return 64'h0123_4567_89AB_0000 + 64'(a) * 64'h0001_0001;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_rd_en) begin
        check("rd_expected", 64'(rdq.size() > 0), 64'd1);
        if (rdq.size() > 0) begin
          re = rdq.pop_front();
          check("rd_bank", 64'(o_rd_bank), 64'(re.bank));
          check("rd_addr", 64'(o_rd_addr), 64'(re.addr));
        end
      end
      if (o_wr_en) begin
        last_wr_cyc = cyc;
        check("wr_expected", 64'(wrq.size() > 0), 64'd1);
        if (wrq.size() > 0) begin
          we = wrq.pop_front();
          check("wr_bank", 64'(o_wr_bank), 64'(we.bank));
          check("wr_addr", 64'(o_wr_addr), 64'(we.addr));
          check("wr_data", o_wr_data, we.data);
        end
      end
      if (!o_busy) run = 0;
      else if (o_eng_reset) run++;
      if (rst_prev && !o_eng_reset) begin
        check("eng_rst_len", 64'(run), 64'd2);
        falls++;
        run = 0;
      end
      rst_prev = o_eng_reset;
    end
  end

  // Entered and left at posedge+#1.
  task automatic run_vec(input vec_t v);
    int   waited;
    int   done_cyc;
    logic rb;
    for (int a = 0; a < NW; a++) begin
      mem[v.src][a]  = pat(a);
      mem[!v.src][a] = 64'hDEAD_BEEF_0000_0000 | 64'(a);
    end
    rdq.delete();
    wrq.delete();
    falls    = 0;
    run      = 0;
    rst_prev = 1'b1;
    mode     = v.mode;
    for (int p = 0; p < v.np; p++) begin
      rb = v.src ^ p[0];
      for (int a = 0; a < NW; a++) rdq.push_back('{rb, a, 64'd0});
      for (int a = 0; a < v.words; a++) wrq.push_back('{!rb, a, pat(a)});
    end
    mon_en       = 1'b1;
    i_start      = 1'b1;
    i_num_passes = PW'(v.np);
    i_src_bank   = v.src;
    @(posedge clk);
    #1 i_start = 1'b0;
    waited = 0;
    while (!o_done && waited < 3000) begin
      @(posedge clk);
      #1 waited++;
    end
    done_cyc = cyc;
    check({v.name, " done_seen"}, 64'(o_done), 64'd1);
    if (v.np == 0) check({v.name, " done_latency"}, 64'(waited), 64'd0);
    check({v.name, " result_bank"}, 64'(o_result_bank), 64'(v.exp_bank));
    check({v.name, " error"}, 64'(o_error), 64'(v.exp_err));
    check({v.name, " busy_at_done"}, 64'(o_busy), 64'(v.exp_busy));
    if (v.mode == 2) check({v.name, " timeout_gap"}, 64'(done_cyc - last_wr_cyc), 64'(TO));
    @(posedge clk);
    #1;
    check({v.name, " done_pulse"}, 64'(o_done), 64'd0);
    check({v.name, " idle"}, 64'(o_busy), 64'd0);
    check({v.name, " result_hold"}, 64'(o_result_bank), 64'(v.exp_bank));
    check({v.name, " rd_left"}, 64'(rdq.size()), 64'd0);
    check({v.name, " wr_left"}, 64'(wrq.size()), 64'd0);
    check({v.name, " eng_rst_pulses"}, 64'(falls), 64'(v.np));
    mon_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " busy"}, 64'(o_busy), 64'd0);
    check({tag, " done"}, 64'(o_done), 64'd0);
    check({tag, " error"}, 64'(o_error), 64'd0);
    check({tag, " rd_en"}, 64'(o_rd_en), 64'd0);
    check({tag, " wr_en"}, 64'(o_wr_en), 64'd0);
    check({tag, " eng_valid"}, 64'(o_eng_data_valid), 64'd0);
    check({tag, " eng_reset"}, 64'(o_eng_reset), 64'd1);
    check({tag, " result_bank"}, 64'(o_result_bank), 64'd0);
    check({tag, " rd_bank"}, 64'(o_rd_bank), 64'd0);
    check({tag, " wr_bank"}, 64'(o_wr_bank), 64'd1);
    check({tag, " rd_addr"}, 64'(o_rd_addr), 64'd0);
    check({tag, " wr_addr"}, 64'(o_wr_addr), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int waited;
    vecs[0] = '{"one_pass",   1, 1'b0, 0, 16, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{"three_pass", 3, 1'b1, 0, 16, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"zero_pass",  0, 1'b1, 0, 16, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"extra_word", 1, 1'b0, 1, 16, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{"stall",      1, 1'b1, 2, 10, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"two_pass",   2, 1'b0, 0, 16, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    i_reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort mid-FEED with reset, then a clean pass.
    mode = 0;
    for (int a = 0; a < NW; a++) mem[0][a] = pat(a);
    i_start      = 1'b1;
    i_num_passes = PW'(2);
    i_src_bank   = 1'b0;
    @(posedge clk);
    #1 i_start = 1'b0;
    waited = 0;
    while (!(o_rd_en && o_rd_addr == AW'(7)) && waited < 200) begin
      @(posedge clk);
      #1 waited++;
    end
    check("abort reached_addr7", 64'(o_rd_addr), 64'd7);
    i_reset_n = 1'b0;
    @(posedge clk);
    #1 check_reset_values("abort");
    i_reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check("abort no_done", 64'(o_done), 64'd0);
    end
    run_vec('{"post_reset", 1, 1'b1, 0, 16, 1'b0, 1'b0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
